// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with multi-beat line refill.
// Define ICACHE_STATS_EN to add the hit_count / miss_count statistics outputs.
module icache_fetch #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 16,
    parameter int BLOCK_WORDS   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     stall,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - 2 - OFF_W - IDX_W;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    state_t                   r_state;
    logic [OFF_W-1:0]         r_beat;
    logic [IDX_W-1:0]         r_index;
    logic [TAG_W-1:0]         r_line_tag;
    logic                     r_mem_req;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [SETS-1:0]          r_valid;
    logic [TAG_W-1:0]         r_tag  [SETS];
    logic [DATA_WIDTH-1:0]    r_data [SETS*BLOCK_WORDS];

    logic [OFF_W-1:0] w_pc_off;
    logic [IDX_W-1:0] w_pc_index;
    logic [TAG_W-1:0] w_pc_tag;
    logic             w_hit;
    logic             w_miss;
    logic             w_beat_done;
    logic             w_last_beat;
    logic             w_unused_pc;

    assign w_pc_off    = pc[OFF_W+1:2];
    assign w_pc_index  = pc[OFF_W+2 +: IDX_W];
    assign w_pc_tag    = pc[ADDRESS_WIDTH-1 -: TAG_W];
    assign w_unused_pc = &{1'b0, pc[1:0]};

    // Lookups are suppressed while rst is high so every reset cycle reports a stall.
    assign w_hit       = (r_state == S_IDLE) && !rst && r_valid[w_pc_index]
                         && (r_tag[w_pc_index] == w_pc_tag);
    assign w_miss      = (r_state == S_IDLE) && !w_hit;
    assign w_beat_done = (r_state == S_REFILL) && mem_ready && !rst;
    assign w_last_beat = w_beat_done && (&r_beat);

    assign instr    = w_hit ? r_data[{w_pc_index, w_pc_off}] : NOP;
    assign stall    = !w_hit;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_index    <= '0;
            r_line_tag <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state    <= S_REFILL;
                        r_beat     <= '0;
                        r_index    <= w_pc_index;
                        r_line_tag <= w_pc_tag;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {w_pc_tag, w_pc_index, {(OFF_W+2){1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        if (&r_beat) begin
                            r_state    <= S_IDLE;
                            r_beat     <= '0;
                            r_mem_req  <= 1'b0;
                            r_mem_addr <= '0;
                        end else begin
                            r_beat     <= r_beat + 1'b1;
                            r_mem_addr <= r_mem_addr + ADDRESS_WIDTH'(4);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat_done) begin
            r_data[{r_index, r_beat}] <= mem_rdata;
        end
        if (w_last_beat) begin
            r_tag[r_index] <= r_line_tag;
        end
    end

    // A line drops out of service the moment its refill starts and only returns once complete.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[gi] <= 1'b0;
            end else if (w_miss && (w_pc_index == IDX_W'(gi))) begin
                r_valid[gi] <= 1'b0;
            end else if (w_last_beat && (r_index == IDX_W'(gi))) begin
                r_valid[gi] <= 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_icache_fetch.sv
// Randomized self-checking bench for icache_fetch against a line-level cache model.
// Define ICACHE_STATS_EN to also exercise the statistics counters.
module tb_icache_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          n_checks;
    int          n_errors;
    logic [31:0] seed;

    // Reference model: which line base address each set currently holds.
    logic [31:0] model_line [16];
    bit          model_valid [16];

    icache_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .instr     (instr),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        model_clear();
        next_cycle();
        @(negedge clk);
        check("rst_stall", stall, 1'b1);
        check("rst_instr", instr, NOP);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);
`endif
        next_cycle();
        rst = 1'b0;
    endtask

    // One fetch of addr; on a miss every beat is preceded by 'waits' not-ready cycles.
    task automatic fetch(input logic [31:0] addr, input int waits);
        logic [31:0] base;
        int          idx;
        bit          exp_hit;
        int          stall_cnt;
        base      = addr & ~32'hF;
        idx       = int'((addr >> 4) & 32'hF);
        exp_hit   = model_valid[idx] && (model_line[idx] == base);
        stall_cnt = 0;
        pc        = addr;
        mem_ready = 1'b0;
        @(negedge clk);
        if (exp_hit) begin
            check("hit_stall", stall, 1'b0);
            check("hit_instr", instr, mem_word(addr));
            check("hit_mem_req", mem_req, 1'b0);
        end else begin
            check("miss_stall", stall, 1'b1);
            check("miss_instr", instr, NOP);
            check("miss_mem_req", mem_req, 1'b0);
            stall_cnt += int'(stall);
            next_cycle();
            for (int b = 0; b < 4; b++) begin
                for (int w = 0; w <= waits; w++) begin
                    mem_ready = (w == waits);
                    @(negedge clk);
                    check("refill_mem_req", mem_req, 1'b1);
                    check("refill_mem_addr", mem_addr, base + 32'(4 * b));
                    check("refill_instr", instr, NOP);
                    stall_cnt += int'(stall);
                    next_cycle();
                end
            end
            mem_ready = 1'b0;
            @(negedge clk);
            check("post_fill_stall", stall, 1'b0);
            check("post_fill_instr", instr, mem_word(addr));
            check("post_fill_mem_req", mem_req, 1'b0);
            check("stall_cycles", 32'(stall_cnt), 32'(1 + 4 * (waits + 1)));
            model_valid[idx] = 1'b1;
            model_line[idx]  = base;
        end
        $display("fetch pc=%h %s waits=%0d stall_cycles=%0d", addr,
                 exp_hit ? "hit " : "miss", waits, stall_cnt);
        next_cycle();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        seed      = $urandom;
        pc        = 32'h0;
        rst       = 1'b1;
        mem_ready = 1'b0;
        model_clear();
        next_cycle();
        do_reset();

        // Cold miss, spatial hits, conflict refills, wait states
        fetch(32'h0000_0000, 0);
        fetch(32'h0000_0008, 0);
        fetch(32'h0000_000C, 0);
        fetch(32'h0000_0100, 0);
        fetch(32'h0000_0000, 0);
        fetch(32'h0000_0200, 2);
        fetch(32'h0000_0204, 0);

        // Reset after two accepted beats of the 0x40 refill
        pc        = 32'h0000_0040;
        mem_ready = 1'b0;
        next_cycle();
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", stall, 1'b1);
        check("midrst_instr", instr, NOP);
        next_cycle();
        rst       = 1'b0;
        mem_ready = 1'b0;
        model_clear();
        $display("reset asserted mid-refill of pc=00000040");
        fetch(32'h0000_0040, 0);

        // Randomized fetch stream
        for (int i = 0; i < 60; i++) begin
            fetch(32'($urandom_range(0, 255)) << 2, int'($urandom_range(0, 2)));
        end

`ifdef ICACHE_STATS_EN
        do_reset();
        fetch(32'h0000_0080, 0);
        fetch(32'h0000_0084, 0);
        fetch(32'h0000_0088, 0);
        fetch(32'h0000_008C, 0);
        @(negedge clk);
        check("stats_miss_count", miss_count, 32'd1);
        check("stats_hit_count", hit_count, 32'd4);
        next_cycle();
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
